// File: rtl/qspi_flash_responder.sv
// Flash-side QSPI responder: emulates a quad-I/O fast-read (0xEB) flash on oversampled pins
// and serves data from a byte-wide synchronous memory with one-byte prefetch.
module qspi_flash_responder #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DUMMY_CLKS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_in,
    input  logic              cs_n_in,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              cont_mode,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_MODE   = 3'd3,
        ST_DUMMY  = 3'd4,
        ST_DATA   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0]        sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]        cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][3:0]   io_sync_q, io_sync_d;
    logic                          sck_prev_q, sck_prev_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [19:0]                   sh_q, sh_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic                          mem_rd_q, mem_rd_d;
    logic                          rd_pend_q, rd_pend_d;
    logic [7:0]                    next_byte_q, next_byte_d;
    logic [7:0]                    cur_byte_q, cur_byte_d;
    logic                          nib_sel_q, nib_sel_d;
    logic [3:0]                    io_out_q, io_out_d;
    logic [3:0]                    io_oe_q, io_oe_d;
    logic                          cont_mode_q, cont_mode_d;
    logic                          busy_q, busy_d;

    logic       sck_s, cs_n_s, sck_rise_s, sck_fall_s;
    logic [3:0] io_s;
    logic [7:0] cmd_byte_s;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s     = cs_sync_q[SYNC_STAGES-1];
    assign io_s       = io_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign cmd_byte_s = {sh_q[6:0], io_s[0]};

    // Next-state logic: pin synchronizers, protocol FSM, prefetch and output nibble selection.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        io_sync_d   = {io_sync_q[SYNC_STAGES-2:0], io_in};
        sck_prev_d  = sck_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        rd_pend_d   = mem_rd_q;
        cur_byte_d  = cur_byte_q;
        nib_sel_d   = nib_sel_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        cont_mode_d = cont_mode_q;

        // Memory answers one clk after the strobe; park it for the next byte boundary.
        if (rd_pend_q) begin
            next_byte_d = mem_data;
        end else begin
            next_byte_d = next_byte_q;
        end

        if (cs_n_s) begin
            state_d   = ST_IDLE;
            io_oe_d   = 4'h0;
            mem_rd_d  = 1'b0;
            cnt_d     = 8'd0;
            nib_sel_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = cont_mode_q ? ST_ADDR : ST_CMD;
                    cnt_d     = 8'd0;
                    nib_sel_d = 1'b0;
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        sh_d = {sh_q[18:0], io_s[0]};
                        if (cnt_q == 8'd7) begin
                            cnt_d   = 8'd0;
                            state_d = (cmd_byte_s == 8'hEB) ? ST_ADDR : ST_IGNORE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        sh_d = sh_q;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        sh_d = {sh_q[15:0], io_s};
                        if (cnt_q == 8'd5) begin
                            cnt_d   = 8'd0;
                            addr_d  = ADDR_W'({sh_q[19:0], io_s});
                            state_d = ST_MODE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        sh_d = sh_q;
                    end
                end
                ST_MODE: begin
                    if (sck_rise_s) begin
                        sh_d = {sh_q[15:0], io_s};
                        if (cnt_q == 8'd1) begin
                            // Mode bits [5:4] are the low half of the first mode nibble.
                            cont_mode_d = (sh_q[1:0] == 2'b10);
                            cnt_d       = 8'd0;
                            state_d     = ST_DUMMY;
                            mem_addr_d  = addr_q;
                            mem_rd_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        sh_d = sh_q;
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise_s) begin
                        if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
                            cnt_d     = 8'd0;
                            nib_sel_d = 1'b0;
                            state_d   = ST_DATA;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DATA: begin
                    if (sck_fall_s) begin
                        if (!nib_sel_q) begin
                            io_oe_d    = 4'hF;
                            io_out_d   = next_byte_q[7:4];
                            cur_byte_d = next_byte_q;
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            mem_rd_d   = 1'b1;
                            nib_sel_d  = 1'b1;
                        end else begin
                            io_out_d  = cur_byte_q[3:0];
                            nib_sel_d = 1'b0;
                        end
                    end else begin
                        io_out_d = io_out_q;
                    end
                end
                ST_IGNORE: begin
                    io_oe_d = 4'h0;
                end
                default: begin
                    state_d = ST_IDLE;
                    io_oe_d = 4'h0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            io_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            cnt_q       <= 8'd0;
            sh_q        <= 20'd0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            next_byte_q <= 8'd0;
            cur_byte_q  <= 8'd0;
            nib_sel_q   <= 1'b0;
            io_out_q    <= 4'h0;
            io_oe_q     <= 4'h0;
            cont_mode_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            io_sync_q   <= io_sync_d;
            sck_prev_q  <= sck_prev_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            rd_pend_q   <= rd_pend_d;
            next_byte_q <= next_byte_d;
            cur_byte_q  <= cur_byte_d;
            nib_sel_q   <= nib_sel_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            cont_mode_q <= cont_mode_d;
            busy_q      <= busy_d;
        end
    end

    assign io_out    = io_out_q;
    assign io_oe     = io_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign cont_mode = cont_mode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: acts as QSPI initiator and as the byte memory
// (which returns addr[7:0]^0x5A); expected nibbles and addresses are written out by hand.
module tb_qspi_flash_responder;

    localparam int ADDR_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int DUMMY_CLKS  = 4;
    localparam int HALF        = 6;

    logic              clk;
    logic              rst_n;
    logic              sck_in;
    logic              cs_n_in;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              cont_mode;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] rd_log[$];
    int consec_rd = 0;
    int oe_seen   = 0;
    logic mem_rd_prev = 1'b0;

    qspi_flash_responder #(
        .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES), .DUMMY_CLKS(DUMMY_CLKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sck_in(sck_in), .cs_n_in(cs_n_in), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .cont_mode(cont_mode), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model: data valid the clk after the strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem_addr[7:0] ^ 8'h5A;
        end
    end

    initial begin
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                rd_log.push_back(mem_addr);
                if (mem_rd_prev) consec_rd++;
            end
            mem_rd_prev = mem_rd;
            if (io_oe != 4'h0 && dut.state_q == 3'd6) oe_seen++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck period: data set while low, io_out sampled just before the rising edge.
    task automatic sck_cycle(input logic [3:0] d, input logic drop, output logic [3:0] q);
        io_in = d;
        tick(HALF);
        q = io_out;
        sck_in = 1'b1;
        tick(HALF);
        if (drop) sck_in = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        logic [3:0] q;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, 1'b1, q);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] q;
        for (int i = 5; i >= 0; i--) sck_cycle(a[4*i +: 4], 1'b1, q);
    endtask

    task automatic send_mode_dummy(input logic [7:0] m);
        logic [3:0] q;
        sck_cycle(m[7:4], 1'b1, q);
        sck_cycle(m[3:0], 1'b1, q);
        for (int i = 0; i < DUMMY_CLKS; i++) sck_cycle(4'h0, 1'b1, q);
    endtask

    task automatic read_data(input string tag, input int n, input logic [31:0] exp);
        logic [3:0] q;
        for (int i = 0; i < n; i++) begin
            sck_cycle(4'h0, (i != n - 1), q);
            check_eq(tag, {28'd0, q}, {28'd0, exp[4*(n-1-i) +: 4]});
            if (i == 0) check_eq({tag, "_oe"}, {28'd0, io_oe}, 32'h0000000F);
        end
    endtask

    task automatic begin_txn();
        cs_n_in = 1'b0;
        tick(HALF);
    endtask

    task automatic end_txn();
        tick(2);
        cs_n_in = 1'b1;
        tick(1);
        sck_in = 1'b0;
        io_in = 4'h0;
        tick(10);
    endtask

    initial begin
        int bad;
        logic [3:0] q;
        rst_n = 1'b0; cs_n_in = 1'b1; sck_in = 1'b0; io_in = 4'h0;
        for (int i = 0; i < 10; i++) begin
            sck_in = ~sck_in;
            tick(3);
        end
        check_eq("rst_io_out", {28'd0, io_out}, 32'd0);
        check_eq("rst_io_oe", {28'd0, io_oe}, 32'd0);
        check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check_eq("rst_cont", {31'd0, cont_mode}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) sck_in = ~sck_in;
            tick(1);
            if (io_oe != 4'h0 || mem_rd || busy) bad++;
        end
        check_eq("idle_quiet", bad, 32'd0);
        sck_in = 1'b0;
        tick(10);

        // Plain 0xEB read, 4 bytes from 0x100.
        rd_log.delete();
        begin_txn();
        send_cmd(8'hEB);
        check_eq("busy_txn", {31'd0, busy}, 32'd1);
        send_addr(24'h000100);
        send_mode_dummy(8'h00);
        read_data("t1_data", 8, 32'h5A5B5859);
        end_txn();
        check_eq("t1_nrd", rd_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < rd_log.size(); i++)
            check_eq("t1_addr", {16'd0, rd_log[i]}, 32'h100 + i);
        check_eq("t1_cont", {31'd0, cont_mode}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_oe_off", {28'd0, io_oe}, 32'd0);

        // Same read with mode 0xA0 arms continuous mode.
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000100);
        send_mode_dummy(8'hA0);
        read_data("t2_data", 4, 32'h00005A5B);
        end_txn();
        check_eq("t2_cont", {31'd0, cont_mode}, 32'd1);

        // Continuous: address straight after cs_n, mode 0xFF disarms.
        begin_txn();
        send_addr(24'h000200);
        send_mode_dummy(8'hFF);
        read_data("t3_data", 2, 32'h0000005A);
        end_txn();
        check_eq("t3_cont", {31'd0, cont_mode}, 32'd0);

        // Unsupported command: ignored until cs_n high.
        rd_log.delete();
        oe_seen = 0;
        begin_txn();
        send_cmd(8'h03);
        for (int i = 0; i < 64; i++) sck_cycle(4'(i), 1'b1, q);
        check_eq("t4_busy", {31'd0, busy}, 32'd1);
        check_eq("t4_oe", {28'd0, io_oe}, 32'd0);
        end_txn();
        check_eq("t4_nrd", rd_log.size(), 32'd0);
        check_eq("t4_oe_seen", oe_seen, 32'd0);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000034);
        send_mode_dummy(8'h00);
        read_data("t4_after", 2, 32'h0000006E);
        end_txn();

        // Abort after 3 address nibbles.
        begin_txn();
        send_cmd(8'hEB);
        for (int i = 0; i < 3; i++) sck_cycle(4'h1, 1'b1, q);
        check_eq("t5_busy_pre", {31'd0, busy}, 32'd1);
        cs_n_in = 1'b1;
        tick(SYNC_STAGES + 2);
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_oe", {28'd0, io_oe}, 32'd0);
        tick(8);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        send_mode_dummy(8'h00);
        read_data("t5_after", 2, 32'h0000004A);
        end_txn();

        // Address wrap at 2^ADDR_W.
        rd_log.delete();
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h00FFFF);
        send_mode_dummy(8'h00);
        read_data("t6_data", 4, 32'h0000A55A);
        end_txn();
        check_eq("t6_nrd", rd_log.size(), 32'd3);
        if (rd_log.size() >= 2) begin
            check_eq("t6_addr0", {16'd0, rd_log[0]}, 32'h0000FFFF);
            check_eq("t6_addr1", {16'd0, rd_log[1]}, 32'h00000000);
        end
        check_eq("rd_consecutive", consec_rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
